spi_burst_dcd: RTL and testbench
================================

Name: spi_burst_dcd

Overview:
- Byte-level command decoder between the SPI slave byte interface and the register file.
- Successor to the single-byte decoder: parametrised address and data word width, with multi-byte words (MSB first).
- Adds auto-increment burst mode, frame termination and an error flag.
- One command byte is followed by DATA_BYTES bytes per word; in burst mode, further words follow until the frame ends.

Parameters:
- ADDR_W, 6, register address width; the command byte carries addr in bits [ADDR_W-1:0]; ADDR_W <= 6.
- DATA_BYTES, 2, bytes per register word; DATA_W = 8*DATA_BYTES; 1..4.
- BURST_EN, 1, when 0 the command burst bit is ignored and every transaction is single-word.

Ports:
- clk  in  1  peripheral clock
- rst_n  in  1  asynchronous active-low reset
- byte_sync  in  1  one-cycle pulse: data_in holds a complete received byte
- data_in  in  8  received SPI byte
- frame_end  in  1  one-cycle pulse on chip-select release; aborts or ends the transaction
- data_out  out  8  byte to transmit on the next SPI byte
- read  out  1  one-cycle register read strobe
- write  out  1  one-cycle register write strobe
- addr  out  ADDR_W  register address, valid with read/write and held afterwards
- data_read  in  DATA_W  register read data, valid the cycle after read
- data_write  out  DATA_W  register write data, valid with write and held afterwards
- err  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset: all outputs 0, state CMD, byte counter 0, all internal registers 0. Reset mid-transaction discards it and no strobe is issued.
- Command byte format: bit7 = rw (1 write, 0 read); bit6 = burst; bits[5:0] = address.
- State CMD:
  - On byte_sync, latch rw, burst (forced 0 if BURST_EN=0) and addr; set count = 0.
  - Write command -> WDATA.
  - Read command -> RD_REQ.
- State RD_REQ: one cycle; read = 1 with addr; -> RD_CAP.
- State RD_CAP: one cycle.
  - Capture data_read into the shift buffer.
  - data_out = buffer[DATA_W-1:DATA_W-8].
  - -> RDATA.
- State RDATA, on each byte_sync:
  - Shift the buffer left 8; data_out = next byte; count += 1.
  - On the DATA_BYTES-th byte with burst: addr += 1, wrapping modulo 2^ADDR_W; -> RD_REQ.
  - On the DATA_BYTES-th byte without burst: -> CMD; data_out holds its last value.
  - Incoming data_in bytes are ignored (dummy bytes).
- State WDATA, on each byte_sync:
  - Shift data_in into the assembly register, MSB first; count += 1.
  - On the DATA_BYTES-th byte: next cycle write = 1, data_write = assembled word, addr = current addr.
  - Then with burst: addr += 1 (wrap) after the strobe cycle and stay in WDATA with count = 0.
  - Then without burst: -> CMD.
- Latency:
  - Write strobe: 1 cycle after the last data byte_sync.
  - Read strobe: 1 cycle after the command or last byte_sync; data_out valid 2 cycles later.
- byte_sync during RD_REQ or RD_CAP: the byte is still counted, err pulses, and data_out is not updated for that byte.
- frame_end in any state:
  - Next state CMD; count = 0.
  - A partially assembled write word is discarded with no write strobe.
  - A pending read completes its strobe only if already in RD_REQ.
  - data_out, addr and data_write hold their values.
- frame_end together with byte_sync: frame_end wins and the byte is discarded.
- read and write are never asserted in the same cycle.

Decomposition:
- Shared package spi_pkg:
  - Command bit positions CMD_RW_BIT = 7 and CMD_BURST_BIT = 6.
  - Enumerated state type (CMD, RD_REQ, RD_CAP, RDATA, WDATA).
- One sub-module is natural: byte_shift_reg, a DATA_BYTES-deep 8-bit shift register with a parallel load port.
  - The write path uses it for assembly; the read path uses it for serialisation.
  - Use two instances.

Test Plan:
- Single write (DATA_BYTES=2): bytes 0x85, 0x12, 0x34 -> one write pulse, addr = 0x05, data_write = 0x1234; read never asserted.
- Single read: 0x0A, then data_read = 0xBEEF at addr 0x0A -> read pulse 1 cycle after the command, data_out = 0xBE, then 0xEF after the next byte_sync; return to CMD.
- Burst write with wrap: 0xFF, then 6 data bytes 11 22 33 44 55 66 -> three writes: 0x3F/0x1122, 0x00/0x3344, 0x01/0x5566.
- Burst read: 0x50 (read, burst, addr 0x10) for 4 data bytes -> read pulses at addr 0x10 then 0x11, data_out streams both words MSB first.
- Abort: 0x83, 0xAA, then frame_end -> no write pulse; the next command 0x84 starts cleanly.
- Error and reset: byte_sync in the cycle after a read strobe -> err pulse. rst_n asserted mid-burst -> all outputs 0 immediately, state CMD.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and state type for the SPI burst command decoder.
// The command byte layout is fixed here; address width is a decoder parameter.
package spi_pkg;

    localparam int CMD_RW_BIT    = 7;
    localparam int CMD_BURST_BIT = 6;
    localparam int CNT_W         = 4;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_RDATA,
        ST_WDATA
    } state_t;

endpackage

// File: rtl/byte_shift_reg.sv
// DATA_BYTES-deep byte shift register with parallel load; bytes enter at the
// LSB end so the oldest byte sits in the top byte (MSB-first words).
module byte_shift_reg #(
    parameter int DATA_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [8*DATA_BYTES-1:0] i_load_data,
    input  logic                    i_shift,
    input  logic [7:0]              i_shift_in,
    output logic [8*DATA_BYTES-1:0] o_data
);

    localparam int DATA_W = 8 * DATA_BYTES;

    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_shifted;

    generate
        if (DATA_BYTES == 1) begin : g_single
            assign w_shifted = i_shift_in;
        end else begin : g_multi
            assign w_shifted = {r_data[DATA_W-9:0], i_shift_in};
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
        end else if (i_shift) begin
            r_data <= w_shifted;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/spi_burst_dcd.sv
// SPI byte-stream command decoder: one command byte, then DATA_BYTES-byte words
// MSB first, with optional auto-increment bursts until frame_end.
module spi_burst_dcd
    import spi_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int DATA_BYTES = 2,
    parameter bit BURST_EN   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    byte_sync,
    input  logic [7:0]              data_in,
    input  logic                    frame_end,
    output logic [7:0]              data_out,
    output logic                    read,
    output logic                    write,
    output logic [ADDR_W-1:0]       addr,
    input  logic [8*DATA_BYTES-1:0] data_read,
    output logic [8*DATA_BYTES-1:0] data_write,
    output logic                    err
);

    localparam int DATA_W = 8 * DATA_BYTES;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_inc;
    logic              r_burst;
    logic              r_write;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data_write;
    logic [DATA_W-1:0] w_asm;
    logic [DATA_W-1:0] w_rbuf;
    logic [DATA_W-1:0] w_wword;
    logic [DATA_W+7:0] w_wcat;
    logic              w_byte;
    logic              w_last;
    logic              w_in_rd_gap;
    logic              w_rd_load;
    logic              w_rd_shift;
    logic              w_wr_shift;
    logic              w_unused;

    // frame_end outranks a coincident byte, so that byte is never seen.
    assign w_byte      = byte_sync & ~frame_end;
    assign w_count_inc = r_count + 1'b1;
    assign w_last      = (w_count_inc >= CNT_W'(DATA_BYTES));
    assign w_in_rd_gap = (r_state == ST_RD_REQ) || (r_state == ST_RD_CAP);

    // Word as it will stand once the current data_in byte is shifted in.
    assign w_wcat   = {w_asm, data_in};
    assign w_wword  = w_wcat[DATA_W-1:0];
    assign w_unused = ^{w_wcat[DATA_W+7:DATA_W], w_rbuf};

    // NOTE: every always_comb output gets a default before the case, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_load   = 1'b0;
        w_rd_shift  = 1'b0;
        w_wr_shift  = 1'b0;
        case (r_state)
            ST_CMD: begin
                if (w_byte) begin
                    w_state_nxt = data_in[CMD_RW_BIT] ? ST_WDATA : ST_RD_REQ;
                end
            end
            ST_RD_REQ: w_state_nxt = ST_RD_CAP;
            ST_RD_CAP: begin
                w_rd_load   = ~frame_end;
                w_state_nxt = ST_RDATA;
            end
            ST_RDATA: begin
                if (w_byte) begin
                    if (w_last) begin
                        w_state_nxt = r_burst ? ST_RD_REQ : ST_CMD;
                    end else begin
                        w_rd_shift = 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                if (w_byte) begin
                    w_wr_shift = 1'b1;
                    if (w_last && !r_burst) begin
                        w_state_nxt = ST_CMD;
                    end
                end
            end
            default: w_state_nxt = ST_CMD;
        endcase
        if (frame_end) begin
            w_state_nxt = ST_CMD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_CMD;
            r_count      <= '0;
            r_burst      <= 1'b0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_data_write <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_write <= (r_state == ST_WDATA) && w_byte && w_last;
            r_err   <= w_byte && w_in_rd_gap;

            // A byte landing in the read request gap still consumes a word slot.
            if (frame_end) begin
                r_count <= '0;
            end else if (w_byte) begin
                if ((r_state == ST_CMD) ||
                    (((r_state == ST_RDATA) || (r_state == ST_WDATA)) && w_last)) begin
                    r_count <= '0;
                end else begin
                    r_count <= w_count_inc;
                end
            end

            if ((r_state == ST_CMD) && w_byte) begin
                r_burst <= BURST_EN && data_in[CMD_BURST_BIT];
                r_addr  <= data_in[ADDR_W-1:0];
            end else if (r_write && r_burst && !frame_end) begin
                r_addr <= r_addr + 1'b1;
            end else if ((r_state == ST_RDATA) && w_byte && w_last && r_burst) begin
                r_addr <= r_addr + 1'b1;
            end

            if ((r_state == ST_WDATA) && w_byte && w_last) begin
                r_data_write <= w_wword;
            end
        end
    end

    byte_shift_reg #(.DATA_BYTES(DATA_BYTES)) u_wr_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (1'b0),
        .i_load_data ('0),
        .i_shift     (w_wr_shift),
        .i_shift_in  (data_in),
        .o_data      (w_asm)
    );

    byte_shift_reg #(.DATA_BYTES(DATA_BYTES)) u_rd_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_rd_load),
        .i_load_data (data_read),
        .i_shift     (w_rd_shift),
        .i_shift_in  (8'h00),
        .o_data      (w_rbuf)
    );

    assign data_out   = w_rbuf[DATA_W-1 -: 8];
    assign read       = (r_state == ST_RD_REQ);
    assign write      = r_write;
    assign addr       = r_addr;
    assign data_write = r_data_write;
    assign err        = r_err;

endmodule

// File: tb/tb_spi_burst_dcd.sv
// Directed bench for spi_burst_dcd: byte-level transaction model feeds an
// expected-strobe queue that a per-cycle compare process checks.
module tb_spi_burst_dcd;

    localparam int GAP   = 4;
    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_ERR = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        byte_sync;
    logic [7:0]  data_in;
    logic        frame_end;
    logic [7:0]  data_out;
    logic        read;
    logic        write;
    logic [5:0]  addr;
    logic [15:0] data_read;
    logic [15:0] data_write;
    logic        err;

    typedef struct {
        int          kind;
        int          cyc;
        logic [5:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mem [0:63];
    logic [7:0]  tx  [0:7];
    int          cyc   = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    spi_burst_dcd #(.ADDR_W(6), .DATA_BYTES(2), .BURST_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .frame_end  (frame_end),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_read  (data_read),
        .data_write (data_write),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign data_read = mem[addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int c, input logic [5:0] a, input logic [15:0] d);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    // Strobes are compared against the head of the expected queue, cycle-exact.
    task automatic match(input int kind, input string nm);
        if (q.size() > 0 && q[0].cyc == cyc) begin
            check({nm, "_kind"}, kind, q[0].kind);
            if (kind == q[0].kind && kind != K_ERR) begin
                check({nm, "_addr"}, addr, q[0].addr);
            end
            if (kind == q[0].kind && kind == K_WR) begin
                check({nm, "_data"}, data_write, q[0].data);
            end
            void'(q.pop_front());
        end else begin
            check({"spurious_", nm}, 1'b1, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                check($sformatf("missing_strobe_kind%0d", q[0].kind), cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (read)  check("read_write_overlap", write, 1'b0);
            if (read)  match(K_RD, "read");
            if (write) match(K_WR, "write");
            if (err)   match(K_ERR, "err");
        end
    end

    task automatic put_byte(input logic [7:0] b, input logic fe, output int c);
        @(negedge clk);
        data_in   = b;
        byte_sync = 1'b1;
        frame_end = fe;
        c         = cyc;
    endtask

    task automatic settle(input int n);
        @(negedge clk);
        byte_sync = 1'b0;
        frame_end = 1'b0;
        data_in   = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        frame_end = 1'b1;
        settle(GAP);
    endtask

    // Write frame: command, then n data bytes from tx[], then frame_end.
    task automatic run_write(input logic [7:0] cmd, input int n);
        int          c;
        int          k;
        logic [5:0]  a;
        logic [15:0] w;
        a = cmd[5:0];
        k = 0;
        w = 16'h0000;
        put_byte(cmd, 1'b0, c);
        settle(GAP);
        for (int i = 0; i < n; i++) begin
            put_byte(tx[i], 1'b0, c);
            w = {w[7:0], tx[i]};
            k++;
            if (k == 2) begin
                expect_ev(K_WR, c + 1, a, w);
                if (cmd[6]) a = a + 6'd1;
                k = 0;
            end
            settle(GAP);
        end
        end_frame();
    endtask

    // Read frame: command, then n dummy bytes; data_out checked after each byte.
    task automatic run_read(input logic [7:0] cmd, input int n);
        int          c;
        int          k;
        logic [5:0]  a;
        logic [15:0] w;
        logic [7:0]  dout;
        a = cmd[5:0];
        k = 0;
        put_byte(cmd, 1'b0, c);
        expect_ev(K_RD, c + 1, a, 16'h0000);
        settle(GAP);
        w    = mem[a];
        dout = w[15:8];
        check("rd_first_byte", data_out, dout);
        for (int i = 0; i < n; i++) begin
            put_byte(8'hA5, 1'b0, c);
            k++;
            if (k < 2) begin
                dout = w[7:0];
            end else begin
                k = 0;
                if (cmd[6]) begin
                    a = a + 6'd1;
                    expect_ev(K_RD, c + 1, a, 16'h0000);
                    w    = mem[a];
                    dout = w[15:8];
                end
            end
            settle(GAP);
            check($sformatf("rd_dout_byte%0d", i), data_out, dout);
        end
        end_frame();
        check("rd_dout_hold_after_frame", data_out, dout);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        for (int i = 0; i < 64; i++) mem[i] = 16'(i * 257) ^ 16'h5A5A;
        mem[6'h0A] = 16'hBEEF;
        mem[6'h10] = 16'hA1B2;
        mem[6'h11] = 16'hC3D4;
        mem[6'h12] = 16'hE5F6;

        rst_n     = 1'b0;
        byte_sync = 1'b0;
        data_in   = 8'h00;
        frame_end = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 8'h00);
        check("rst_read", read, 1'b0);
        check("rst_write", write, 1'b0);
        check("rst_addr", addr, 6'h00);
        check("rst_data_write", data_write, 16'h0000);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write 0x85 12 34.
        tx[0] = 8'h12; tx[1] = 8'h34;
        run_write(8'h85, 2);
        check("sw_addr_held", addr, 6'h05);
        check("sw_data_held", data_write, 16'h1234);

        // Single read at 0x0A: BE then EF, then hold.
        run_read(8'h0A, 2);
        check("sr_last_byte", data_out, 8'hEF);

        // Burst write from 0x3F wrapping to 0x00, 0x01.
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
        tx[3] = 8'h44; tx[4] = 8'h55; tx[5] = 8'h66;
        run_write(8'hFF, 6);
        check("bw_last_data", data_write, 16'h5566);
        check("bw_addr_after", addr, 6'h02);

        // Burst read from 0x10: prefetches 0x12 after the fourth byte.
        run_read(8'h50, 4);
        check("br_dout_literal", data_out, 8'hE5);
        check("br_addr_held", addr, 6'h12);

        // Abort a partial write word, then a clean write.
        put_byte(8'h83, 1'b0, c); settle(GAP);
        put_byte(8'hAA, 1'b0, c); settle(GAP);
        end_frame();
        check("abort_addr", addr, 6'h03);
        check("abort_data_held", data_write, 16'h5566);
        tx[0] = 8'h56; tx[1] = 8'h78;
        run_write(8'h84, 2);
        check("post_abort_data", data_write, 16'h5678);

        // frame_end coincident with the final data byte discards it.
        put_byte(8'h87, 1'b0, c); settle(GAP);
        put_byte(8'h99, 1'b0, c); settle(GAP);
        put_byte(8'h77, 1'b1, c); settle(GAP);
        check("fe_byte_data_held", data_write, 16'h5678);
        tx[0] = 8'h01; tx[1] = 8'h02;
        run_write(8'h88, 2);
        check("fe_next_write", data_write, 16'h0102);

        // Byte in the read request gap: err, byte counted, data_out unchanged.
        put_byte(8'h0A, 1'b0, c);
        expect_ev(K_RD, c + 1, 6'h0A, 16'h0000);
        put_byte(8'h3C, 1'b0, c);
        expect_ev(K_ERR, c + 1, 6'h00, 16'h0000);
        settle(GAP);
        check("err_dout_msb", data_out, 8'hBE);
        put_byte(8'h3C, 1'b0, c); settle(GAP);
        check("err_word_done_hold", data_out, 8'hBE);
        tx[0] = 8'h5A; tx[1] = 8'hA5;
        run_write(8'h81, 2);
        check("err_next_write", data_write, 16'h5AA5);

        // Reset in the middle of a burst write.
        put_byte(8'hC0, 1'b0, c); settle(GAP);
        put_byte(8'h11, 1'b0, c); settle(GAP);
        put_byte(8'h22, 1'b0, c);
        expect_ev(K_WR, c + 1, 6'h00, 16'h1122);
        settle(GAP);
        put_byte(8'h33, 1'b0, c); settle(GAP);
        check("mid_addr_before_rst", addr, 6'h01);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data_out", data_out, 8'h00);
        check("mid_rst_addr", addr, 6'h00);
        check("mid_rst_data_write", data_write, 16'h0000);
        check("mid_rst_write", write, 1'b0);
        check("mid_rst_read", read, 1'b0);
        check("mid_rst_err", err, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tx[0] = 8'h9A; tx[1] = 8'hBC;
        run_write(8'h84, 2);
        check("post_rst_write", data_write, 16'h9ABC);

        repeat (10) @(negedge clk);
        check("pending_strobes", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
